wb_pwm4: RTL
============

// Module: wb_pwm4
// PURPOSE
//  Four-channel ESC/motor PWM generator as a Wishbone slave on the conbus (slave slot 0x7xxxxxxx).
//  Sits directly downstream of the interconnect: the LM32 data master writes period/duty words,
//  the block drives four glitch-free PWM lines to the quadcopter ESCs.
//  Duty/period changes are applied only at a period boundary, so no output ever sees a truncated pulse.
// PARAMETERS
//  clk_freq   100000000  system clock frequency, Hz
//  pwm_hz     400        reset-default PWM frequency; PERIOD resets to clk_freq/pwm_hz (250000)
//  wdt_ms     100        watchdog timeout in ms (used only with WB_PWM4_WATCHDOG_EN)
// PORTS
//  clk        in   1   system clock, all logic rising-edge
//  rst        in   1   asynchronous active-low reset (0 = reset)
//  wb_adr_i   in   32  Wishbone address; only [4:2] decoded
//  wb_dat_i   in   32  write data
//  wb_dat_o   out  32  read data, valid while wb_ack_o=1
//  wb_stb_i   in   1   strobe
//  wb_cyc_i   in   1   cycle
//  wb_we_i    in   1   1=write
//  wb_sel_i   in   4   byte selects; ignored, all accesses are full-word
//  wb_ack_o   out  1   single-cycle acknowledge
//  pwm_o      out  4   PWM outputs, registered, active high
//  intr       out  1   one-cycle pulse at each period wrap (while enabled)
// BEHAVIOUR
//  Reset (rst=0, async): pwm_o=0, intr=0, wb_ack_o=0, wb_dat_o=0, CTRL=0, DUTYn=0, shadows=0,
//    cnt=0, PERIOD=clk_freq/pwm_hz.
//  Register map (adr[4:2]): 0 CTRL [0]=enable [1]=wdt_trip(RO) | 1 PERIOD [23:0] |
//    2..5 DUTY0..DUTY3 [23:0] | 6,7 read 0, writes ignored. Unused bits read 0.
//  Bus: ack asserted the cycle after stb&cyc with ack=0; deasserted next cycle (no back-to-back ack);
//    write takes effect on the ack cycle; read data registered with ack. Latency = 1 cycle.
//  PERIOD writes <2 are stored as 2. Counter cnt[23:0] counts 0..PERIOD_sh-1, then wraps to 0.
//  At wrap (cnt==PERIOD_sh-1): PERIOD_sh<=PERIOD, DUTYn_sh<=DUTYn, intr pulses 1 cycle.
//  pwm_o[n] <= enable & (cnt < DUTYn_sh): DUTY=0 -> constant low; DUTY>=PERIOD_sh -> constant high.
//  Output is registered: pwm_o lags the compare by exactly 1 cycle; all 4 channels rise together at cnt=0.
//  enable 1->0: cnt forced to 0, pwm_o=0 next cycle, intr suppressed.
//  enable 0->1: shadows load immediately from PERIOD/DUTYn, cnt starts at 0 (first pulse full length).
//  DUTY write in the same cycle as wrap: the NEW value is loaded into the shadow (write wins).
//  Reset mid-period: outputs drop immediately (async), no partial pulse completed.
// CONFIGURATION
//  `WB_PWM4_WATCHDOG_EN defined: 32-bit wdt counter, cleared by any DUTYn write; on reaching
//    clk_freq/1000*wdt_ms, all DUTYn_sh forced to 0 at the next wrap, CTRL[1] set (sticky until
//    next DUTY write). Protects motors if firmware hangs.
//  Not defined: no watchdog logic, CTRL[1] reads 0, wdt_ms unused.
// STRUCTURE
//  wb_pwm4_defs.vh (shared include): register offsets REG_CTRL..REG_DUTY3, CTRL bit indices,
//    CNT_W=24, PERIOD_MIN=2.
//  Sub-module wb_pwm4_chan: one channel = DUTY register, shadow, comparator, output flop;
//    instantiated 4x. Top holds bus decode, period counter, CTRL, watchdog.
// TESTING
//  1 Reset: hold rst=0 5 cycles -> pwm_o=0, ack=0, read PERIOD returns 250000 after release.
//  2 PERIOD=100, DUTY0=25, DUTY1=0, DUTY2=100, DUTY3=150, enable -> pwm0 high 25/100 cycles,
//    pwm1 always 0, pwm2 and pwm3 always 1; intr every 100 cycles.
//  3 Mid-period DUTY0 25->60 at cnt=40 -> current pulse stays 25 cycles, next period 60 cycles.
//  4 PERIOD write of 0 -> reads back 2; DUTY0=1 -> pwm0 alternates 1,0 each cycle.
//  5 Bus: back-to-back stb held high -> ack pattern 0,1,0,1; read of adr 6 returns 0.
//  6 (WATCHDOG_EN, wdt_ms=1) no DUTY writes 100000 cycles -> pwm_o=0 after next wrap, CTRL[1]=1;
//    DUTY0 write -> CTRL[1]=0, PWM resumes.

Source files
------------

// File: rtl/wb_pwm4_pkg.sv
// rtl/wb_pwm4_pkg.sv - register map, widths and helpers shared by the wb_pwm4 block
package wb_pwm4_pkg;

  localparam int CNT_W = 24;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PERIOD = 3'd1;
  localparam logic [2:0] REG_DUTY0  = 3'd2;
  localparam logic [2:0] REG_DUTY1  = 3'd3;
  localparam logic [2:0] REG_DUTY2  = 3'd4;
  localparam logic [2:0] REG_DUTY3  = 3'd5;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_WDT = 1;

  localparam logic [CNT_W-1:0] PERIOD_MIN = 24'd2;

  // A period below 2 would make the wrap compare degenerate, so it is clamped on write.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] v);
    return (v < PERIOD_MIN) ? PERIOD_MIN : v;
  endfunction

endpackage

// File: rtl/wb_pwm4_chan.sv
// rtl/wb_pwm4_chan.sv - one PWM channel: duty register, period-boundary shadow, compare, output flop
module wb_pwm4_chan
  import wb_pwm4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic             i_load,
  input  logic             i_force_zero,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] o_duty,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_duty_sh;
  logic             r_pwm;
  logic [CNT_W-1:0] w_duty_next;

  // A write landing on the load cycle goes straight into the shadow.
  assign w_duty_next = i_wr ? i_wdata : r_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty    <= '0;
      r_duty_sh <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_duty <= w_duty_next;
      if (i_load) begin
        r_duty_sh <= i_force_zero ? '0 : w_duty_next;
      end
      r_pwm <= i_en & (i_cnt < r_duty_sh);
    end
  end

  assign o_duty = r_duty;
  assign o_pwm  = r_pwm;

endmodule

// File: rtl/wb_pwm4.sv
// rtl/wb_pwm4.sv - four-channel Wishbone PWM generator; optional watchdog under WB_PWM4_WATCHDOG_EN
module wb_pwm4
  import wb_pwm4_pkg::*;
#(
  parameter int clk_freq = 100000000,
  parameter int pwm_hz   = 400,
  parameter int wdt_ms   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [3:0]  pwm_o,
  output logic        intr
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(clk_freq / pwm_hz);

  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_en;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_period_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_intr;

  logic             w_req;
  logic             w_wr;
  logic [2:0]       w_reg;
  logic             w_wrap;
  logic             w_load;
  logic             w_trip;
  logic             w_force_zero;
  logic [CNT_W-1:0] w_period_next;
  logic [3:0]       w_duty_wr;
  logic [CNT_W-1:0] w_duty [4];
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_req  = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr   = w_req & wb_we_i;
  assign w_reg  = wb_adr_i[4:2];
  assign w_wrap = r_en & (r_cnt == r_period_sh - CNT_W'(1));
  // While disabled the shadows track the live registers, so enabling starts a full first period.
  assign w_load = ~r_en | w_wrap;
  assign w_period_next = (w_wr && (w_reg == REG_PERIOD)) ?
                         clamp_period(wb_dat_i[CNT_W-1:0]) : r_period;

  assign w_unused = &{1'b0, wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0],
                      wb_dat_i[31:CNT_W], (wdt_ms != 0)};

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_CTRL: begin
        w_rdata[CTRL_EN]  = r_en;
        w_rdata[CTRL_WDT] = w_trip;
      end
      REG_PERIOD: w_rdata[CNT_W-1:0] = r_period;
      REG_DUTY0:  w_rdata[CNT_W-1:0] = w_duty[0];
      REG_DUTY1:  w_rdata[CNT_W-1:0] = w_duty[1];
      REG_DUTY2:  w_rdata[CNT_W-1:0] = w_duty[2];
      REG_DUTY3:  w_rdata[CNT_W-1:0] = w_duty[3];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_en        <= 1'b0;
      r_period    <= PERIOD_RST;
      r_period_sh <= '0;
      r_cnt       <= '0;
      r_intr      <= 1'b0;
    end else begin
      r_ack    <= w_req;
      r_dat    <= w_req ? w_rdata : '0;
      if (w_wr && (w_reg == REG_CTRL)) begin
        r_en <= wb_dat_i[CTRL_EN];
      end
      r_period <= w_period_next;
      if (w_load) begin
        r_period_sh <= w_period_next;
      end
      r_cnt  <= (!r_en || w_wrap) ? '0 : r_cnt + CNT_W'(1);
      r_intr <= w_wrap;
    end
  end

`ifdef WB_PWM4_WATCHDOG_EN
  localparam logic [31:0] WDT_LIM = 32'(clk_freq / 1000 * wdt_ms);

  logic [31:0] r_wdt;
  logic        r_trip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdt  <= '0;
      r_trip <= 1'b0;
    end else if (|w_duty_wr) begin
      r_wdt  <= '0;
      r_trip <= 1'b0;
    end else begin
      if (r_wdt != WDT_LIM) begin
        r_wdt <= r_wdt + 32'd1;
      end
      if (r_wdt == WDT_LIM) begin
        r_trip <= 1'b1;
      end
    end
  end

  assign w_trip       = r_trip;
  assign w_force_zero = r_trip & ~(|w_duty_wr);
`else
  assign w_trip       = 1'b0;
  assign w_force_zero = 1'b0;
`endif

  for (genvar n = 0; n < 4; n++) begin : g_chan
    assign w_duty_wr[n] = w_wr & (w_reg == (REG_DUTY0 + 3'(n)));

    wb_pwm4_chan u_chan (
      .clk          (clk),
      .rst_n        (rst),
      .i_wr         (w_duty_wr[n]),
      .i_wdata      (wb_dat_i[CNT_W-1:0]),
      .i_load       (w_load),
      .i_force_zero (w_force_zero),
      .i_en         (r_en),
      .i_cnt        (r_cnt),
      .o_duty       (w_duty[n]),
      .o_pwm        (pwm_o[n])
    );
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign intr     = r_intr;

endmodule
